// File: rtl/fsmc_bus_bridge_pkg.sv
// Shared types and constants for the FSMC-to-register-bank bridge.
package fsmc_bus_bridge_pkg;

  // Bridge sequencing states
  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RD_REQ    = 3'd2,
    ST_RD_CAP    = 3'd3,
    ST_RD_HOLD   = 3'd4,
    ST_WR_SAMPLE = 3'd5,
    ST_WR_ISSUE  = 3'd6
  } fsmc_state_e;

  // Fewer than two flops does not give metastability protection on the pins.
  localparam int unsigned C_SYNC_STAGES_MIN = 2;

  // Shortest MCU DATAST (in clk cycles) that still sees read data at NOE rise.
  function automatic int unsigned fsmc_min_datast(input int unsigned sync_stages);
    return sync_stages + 4;
  endfunction

  // Register bank address map
  localparam logic [15:0] REG_ID   = 16'h0000;
  localparam logic [15:0] REG_CTRL = 16'h0001;
  localparam logic [15:0] REG_DATA = 16'h0002;
  localparam logic [15:0] REG_CFG  = 16'h0003;
  localparam logic [15:0] REG_BUF  = 16'h0100;

endpackage

// File: rtl/fsmc_sync.sv
// Multi-flop synchronizer for asynchronous FSMC pins, with a per-instance reset value.
module fsmc_sync #(
  parameter int                 p_WIDTH   = 1,
  parameter int                 p_STAGES  = 2,
  parameter logic [p_WIDTH-1:0] p_RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [p_WIDTH-1:0] d_i,
  output logic [p_WIDTH-1:0] q_o
);

  logic [p_WIDTH-1:0] sr_q [p_STAGES];

  // Shift the pin value through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < p_STAGES; i++) sr_q[i] <= p_RST_VAL;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < p_STAGES; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[p_STAGES-1];

endmodule

// File: rtl/fsmc_bus_bridge.sv
// Converts MCU FSMC async SRAM-mode cycles into single-clock register strobes.
//
// state        | meaning
// WAIT_IDLE    | wait for NE high or both strobes high before accepting a new strobe
// IDLE         | waiting for NOE or NWE to fall
// RD_REQ       | ren high for this one cycle
// RD_CAP       | register bank presents rdata; captured into the pad data register
// RD_HOLD      | drive pad while NOE/NE stay low
// WR_SAMPLE    | NWE low, track addr/data every clk
// WR_ISSUE     | wen high for this one cycle
module fsmc_bus_bridge
  import fsmc_bus_bridge_pkg::*;
#(
  parameter int p_WIDTH_ADDR  = 16,
  parameter int p_WIDTH_DATA  = 16,
  parameter int p_SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fsmc_ne,
  input  logic                    fsmc_noe,
  input  logic                    fsmc_nwe,
  input  logic [p_WIDTH_ADDR-1:0] fsmc_a,
  input  logic [p_WIDTH_DATA-1:0] fsmc_d_i,
  output logic [p_WIDTH_DATA-1:0] fsmc_d_o,
  output logic                    fsmc_d_oe,
  output logic [p_WIDTH_ADDR-1:0] addr,
  output logic [p_WIDTH_DATA-1:0] wdata,
  output logic                    wen,
  output logic                    ren,
  input  logic [p_WIDTH_DATA-1:0] rdata,
  output logic                    proto_err
);

  localparam int STAGES = (p_SYNC_STAGES < int'(C_SYNC_STAGES_MIN)) ?
                          int'(C_SYNC_STAGES_MIN) : p_SYNC_STAGES;
  localparam int CW     = $clog2(STAGES + 1);

  logic                    s_ne, s_noe, s_nwe;
  logic [p_WIDTH_ADDR-1:0] s_a;
  logic [p_WIDTH_DATA-1:0] s_d;

  fsmc_sync #(.p_WIDTH(3), .p_STAGES(STAGES), .p_RST_VAL(3'b111)) u_sync_strb (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({fsmc_ne, fsmc_noe, fsmc_nwe}),
    .q_o   ({s_ne, s_noe, s_nwe})
  );

  fsmc_sync #(.p_WIDTH(p_WIDTH_ADDR), .p_STAGES(STAGES), .p_RST_VAL('0)) u_sync_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (fsmc_a),
    .q_o   (s_a)
  );

  fsmc_sync #(.p_WIDTH(p_WIDTH_DATA), .p_STAGES(STAGES), .p_RST_VAL('0)) u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (fsmc_d_i),
    .q_o   (s_d)
  );

  fsmc_state_e             state_q, state_d;
  logic [p_WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [p_WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [p_WIDTH_DATA-1:0] d_o_q, d_o_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic                    proto_err_q, proto_err_d;
  // The synchronizers reset to "strobes inactive", which would look like a
  // finished cycle; hold WAIT_IDLE until the chain reflects the real pins.
  logic [CW-1:0]           settle_q, settle_d;

  // Register state, bus outputs and the post-reset settle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      d_o_q       <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      proto_err_q <= 1'b0;
      settle_q    <= CW'(STAGES);
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      d_o_q       <= d_o_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      proto_err_q <= proto_err_d;
      settle_q    <= settle_d;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    d_o_d       = d_o_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    proto_err_d = proto_err_q | (~s_noe & ~s_nwe);
    settle_d    = (settle_q == '0) ? settle_q : settle_q - CW'(1);

    case (state_q)
      ST_WAIT_IDLE: begin
        if ((settle_q == '0) && (s_ne || (s_noe && s_nwe))) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!s_noe && !s_nwe) begin
          state_d = ST_WAIT_IDLE;
        end else if (!s_ne && !s_noe) begin
          state_d = ST_RD_REQ;
          addr_d  = s_a;
          ren_d   = 1'b1;
        end else if (!s_ne && !s_nwe) begin
          state_d = ST_WR_SAMPLE;
          addr_d  = s_a;
          wdata_d = s_d;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        d_o_d   = rdata;
        state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (s_noe || s_ne) state_d = ST_WAIT_IDLE;
      end
      ST_WR_SAMPLE: begin
        if (s_nwe) begin
          state_d = ST_WR_ISSUE;
          wen_d   = 1'b1;
        end else if (s_ne) begin
          state_d = ST_WAIT_IDLE;
        end else begin
          addr_d  = s_a;
          wdata_d = s_d;
        end
      end
      ST_WR_ISSUE: begin
        state_d = ST_WAIT_IDLE;
      end
      default: begin
        state_d = ST_WAIT_IDLE;
      end
    endcase
  end

  // Raw pins here so the pad is released the moment the MCU lets go
  assign fsmc_d_oe = (state_q == ST_RD_HOLD) & ~fsmc_noe & ~fsmc_ne;
  assign fsmc_d_o  = d_o_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wen       = wen_q;
  assign ren       = ren_q;
  assign proto_err = proto_err_q;

endmodule
